// File: rtl/adc_serial_config_sequencer.sv
// adc_serial_config_sequencer
//
// Drives the ADC 3-wire configuration port (sclk/sdata/select). Two
// requesters share the port: a power-up init table read from an external
// combinational ROM (triggered by start), and a runtime host write channel.
// Each WORD_W-bit word goes out MSB-first, with one sclk period every DIV
// clk cycles, framed by an active-low select.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   start     pulse: request the full init-table sequence
//   rom_addr  init ROM address (word index; 0 when idle)
//   rom_data  ROM word at rom_addr, combinational
//   wr_req    host write request, held until wr_ack
//   wr_data   host write word
//   wr_ack    one-cycle pulse when wr_data is captured
//   sclk      serial clock to ADC, idle low
//   sdata     serial data to ADC
//   select    ADC chip select, active low
//   busy      high whenever not idle
//   done      set when an init sequence completes; cleared by start
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | port idle; arbitrate init (priority) versus host write
// S_LOAD  | capture ROM or host word into the shift register (1 cycle)
// S_SETUP | select low, sclk low, first bit presented (DIV/2 cycles)
// S_SHIFT | WORD_W sclk periods, low half then high half
// S_HOLD  | sclk low, select still low (DIV/2 cycles)
// S_GAP   | select high, sdata 0 (DIV cycles); next word or idle

module adc_serial_config_sequencer #(
   parameter int WORD_W    = 20,
   parameter int NUM_WORDS = 16,
   parameter int ADDR_W    = 4,
   parameter int DIV       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [WORD_W-1:0] rom_data,
   input  logic              wr_req,
   input  logic [WORD_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              sclk,
   output logic              sdata,
   output logic              select,
   output logic              busy,
   output logic              done
);

   localparam int HALF  = DIV / 2;
   localparam int TMR_W = $clog2(DIV);
   localparam int BIT_W = $clog2(WORD_W);

   localparam logic [TMR_W-1:0]  HALF_LD  = TMR_W'(HALF - 1);
   localparam logic [TMR_W-1:0]  GAP_LD   = TMR_W'(DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LD   = BIT_W'(WORD_W - 1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_GAP
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [TMR_W-1:0]  tmr;
   logic              ph;          // 0: low half of sclk period, 1: high half
   logic [BIT_W-1:0]  bit_cnt;     // bit periods remaining after the current one
   logic [WORD_W-1:0] shreg;
   logic [ADDR_W-1:0] idx;
   logic              src_rom;
   logic              init_pending;
   logic              done_q;

   logic tc;
   logic go_init;
   logic go_host;
   logic last_word_exit;

   assign tc = (tmr == '0);

   always_comb begin
      state_nxt      = state;
      go_init        = 1'b0;
      go_host        = 1'b0;
      last_word_exit = 1'b0;
      case (state)
         S_IDLE: begin
            // start is honoured in the same cycle so LOAD follows it directly
            if (init_pending || start) begin
               state_nxt = S_LOAD;
               go_init   = 1'b1;
            end else if (wr_req) begin
               state_nxt = S_LOAD;
               go_host   = 1'b1;
            end
         end
         S_LOAD:  state_nxt = S_SETUP;
         S_SETUP: if (tc) state_nxt = S_SHIFT;
         S_SHIFT: if (tc && ph && (bit_cnt == '0)) state_nxt = S_HOLD;
         S_HOLD:  if (tc) state_nxt = S_GAP;
         S_GAP: begin
            if (tc) begin
               if (src_rom && (idx != LAST_IDX)) begin
                  state_nxt = S_LOAD;
               end else begin
                  state_nxt      = S_IDLE;
                  last_word_exit = src_rom;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != S_IDLE);
      wr_ack   = (state == S_LOAD) && !src_rom;
      select   = !((state == S_SETUP) || (state == S_SHIFT) || (state == S_HOLD));
      sclk     = (state == S_SHIFT) && ph;
      sdata    = select ? 1'b0 : shreg[WORD_W-1];
      rom_addr = idx;
      done     = done_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         tmr          <= '0;
         ph           <= 1'b0;
         bit_cnt      <= '0;
         shreg        <= '0;
         idx          <= '0;
         src_rom      <= 1'b0;
         init_pending <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state <= state_nxt;

         if (go_init)
            init_pending <= 1'b0;
         else if (start)
            init_pending <= 1'b1;

         // A restart queued during a sequence suppresses done for that
         // sequence; done reflects only a sequence with nothing pending.
         if (start)
            done_q <= 1'b0;
         else if (last_word_exit && !init_pending)
            done_q <= 1'b1;

         case (state)
            S_IDLE: begin
               idx <= '0;
               if (go_init)
                  src_rom <= 1'b1;
               else if (go_host)
                  src_rom <= 1'b0;
            end
            S_LOAD: begin
               shreg <= src_rom ? rom_data : wr_data;
               tmr   <= HALF_LD;
            end
            S_SETUP: begin
               if (tc) begin
                  tmr     <= HALF_LD;
                  ph      <= 1'b0;
                  bit_cnt <= BIT_LD;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            S_SHIFT: begin
               if (tc) begin
                  tmr <= HALF_LD;
                  if (!ph) begin
                     ph <= 1'b1;
                  end else begin
                     ph <= 1'b0;
                     if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                        shreg   <= {shreg[WORD_W-2:0], 1'b0};
                     end
                  end
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            S_HOLD: begin
               if (tc)
                  tmr <= GAP_LD;
               else
                  tmr <= tmr - 1'b1;
            end
            S_GAP: begin
               if (tc) begin
                  tmr <= HALF_LD;
                  if (src_rom && (idx != LAST_IDX))
                     idx <= idx + 1'b1;
                  else
                     idx <= '0;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_serial_config_sequencer.sv
// Bench for adc_serial_config_sequencer. A frame-position model predicts
// every output from the offset within the current word frame; directed
// scenarios add literal expectations on latencies and captured words.
module tb_adc_serial_config_sequencer;

   localparam int W     = 20;
   localparam int NW    = 16;
   localparam int AW    = 4;
   localparam int DIV   = 16;
   localparam int H     = DIV / 2;
   localparam int FRAME = 1 + H + W * DIV + H + DIV;
   localparam logic [W-1:0] ROM_BASE = 20'h80000;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] rom_addr;
   logic [W-1:0]  rom_data;
   logic          wr_req;
   logic [W-1:0]  wr_data;
   logic          wr_ack;
   logic          sclk;
   logic          sdata;
   logic          select;
   logic          busy;
   logic          done;

   adc_serial_config_sequencer #(
      .WORD_W(W), .NUM_WORDS(NW), .ADDR_W(AW), .DIV(DIV)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr),
      .rom_data(rom_data), .wr_req(wr_req), .wr_data(wr_data),
      .wr_ack(wr_ack), .sclk(sclk), .sdata(sdata), .select(select),
      .busy(busy), .done(done)
   );

   assign rom_data = ROM_BASE | {{(W-AW){1'b0}}, rom_addr};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_vec = 0;
   int n_err = 0;

   // model state
   bit         m_valid = 0;
   bit         m_act, m_rom, m_pend, m_done;
   int         m_off, m_idx;
   logic [W-1:0] m_word;

   // bit capture on sclk rising edges, one entry per select frame
   logic         prev_sclk = 1'b0;
   logic         prev_sel  = 1'b1;
   logic [W-1:0] cap_sh = '0;
   int           cap_n = 0;
   int           sclk_rises = 0;
   logic [W-1:0] cap_q[$];
   int           capn_q[$];
   int           sel_low = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit fin_last, took_init;
      fin_last  = 0;
      took_init = 0;
      if (!rst_n) begin
         m_valid = 1; m_act = 0; m_pend = 0; m_done = 0; m_idx = 0; m_off = 0;
      end else if (m_valid) begin
         if (m_act) begin
            m_off++;
            if (m_off == FRAME) begin
               if (m_rom && m_idx < NW - 1) begin
                  m_idx++;
                  m_off  = 0;
                  m_word = ROM_BASE | W'(m_idx);
               end else begin
                  m_act    = 0;
                  fin_last = m_rom;
                  m_idx    = 0;
               end
            end
         end else if (m_pend || start) begin
            m_act = 1; m_rom = 1; m_idx = 0; m_off = 0; m_word = ROM_BASE;
            took_init = 1;
         end else if (wr_req) begin
            m_act = 1; m_rom = 0; m_idx = 0; m_off = 0; m_word = wr_data;
         end
         if (start) m_done = 0;
         else if (fin_last && !m_pend) m_done = 1;
         if (took_init) m_pend = 0;
         else if (start) m_pend = 1;
      end
   endtask

   task automatic compare_outputs();
      logic e_busy, e_sel, e_sclk, e_sd, e_ack;
      bit   e_sdx, ok;
      int   e_addr, p;
      e_busy = 0; e_sel = 1; e_sclk = 0; e_sd = 0; e_ack = 0; e_sdx = 0; e_addr = 0;
      if (m_act) begin
         e_busy = 1;
         e_addr = m_rom ? m_idx : 0;
         if (m_off == 0) begin
            e_ack = !m_rom;
         end else if (m_off <= H) begin
            e_sel = 0; e_sd = m_word[W-1];
         end else if (m_off <= H + W * DIV) begin
            p      = m_off - 1 - H;
            e_sel  = 0;
            e_sclk = ((p % DIV) >= H);
            e_sd   = m_word[W-1-p/DIV];
         end else if (m_off <= 2 * H + W * DIV) begin
            e_sel = 0; e_sdx = 1;
         end
      end
      ok = (busy === e_busy) && (select === e_sel) && (sclk === e_sclk) &&
           (wr_ack === e_ack) && (done === m_done) && (rom_addr === AW'(e_addr)) &&
           (e_sdx || (sdata === e_sd));
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL model t=%0t off=%0d: busy/sel/sclk/sdata/ack/done/addr got %b%b%b%b%b%b/%0d expected %b%b%b%b%b%b/%0d",
                  $time, m_off, busy, select, sclk, sdata, wr_ack, done, rom_addr,
                  e_busy, e_sel, e_sclk, e_sd, e_ack, m_done, e_addr);
      end
   endtask

   task automatic monitor();
      if (sclk === 1'b1 && prev_sclk !== 1'b1) begin
         cap_sh = {cap_sh[W-2:0], sdata};
         cap_n++;
         sclk_rises++;
      end
      if (select === 1'b1 && prev_sel === 1'b0) begin
         cap_q.push_back(cap_sh);
         capn_q.push_back(cap_n);
         cap_n = 0;
      end
      if (select === 1'b0) sel_low++;
      prev_sclk = sclk;
      prev_sel  = select;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (m_valid) compare_outputs();
      monitor();
      if (wr_ack === 1'b1) wr_req = 1'b0;
   endtask

   int n, base, r0;

   initial begin
      rst_n = 1'b0; start = 1'b0; wr_req = 1'b0; wr_data = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("rst_select", select, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_addr", rom_addr, 0);
      check("rst_sclk", sclk, 0);

      // host write
      base = cap_q.size(); sel_low = 0;
      wr_data = 20'hA5A5A; wr_req = 1'b1;
      n = 0;
      do begin tick(); n++; end while (wr_ack !== 1'b1 && n < 10);
      check("host_ack_latency", n, 1);
      n = 0;
      while (busy !== 1'b0 && n < 500) begin tick(); n++; end
      check("host_frame_len", n, FRAME);
      check("host_select_low", sel_low, 336);
      check("host_frames", cap_q.size() - base, 1);
      check("host_word", cap_q[base], 20'hA5A5A);
      check("host_edges", capn_q[base], 20);
      check("host_done", done, 0);

      // init sequence
      base = cap_q.size();
      start = 1'b1; tick(); start = 1'b0; n = 1;
      while (done !== 1'b1 && n < 7000) begin tick(); n++; end
      check("init_done_cycle", n, 5649);
      check("init_frames", cap_q.size() - base, 16);
      for (int k = 0; k < NW; k++) begin
         check($sformatf("init_word%0d", k), cap_q[base+k], ROM_BASE | W'(k));
         check($sformatf("init_edges%0d", k), capn_q[base+k], 20);
      end

      // arbitration: start and wr_req together
      base = cap_q.size();
      wr_data = 20'h3C0F1; wr_req = 1'b1; start = 1'b1;
      tick(); start = 1'b0; n = 1;
      while (wr_ack !== 1'b1 && n < 7000) begin tick(); n++; end
      check("arb_ack_cycle", n, 5650);
      check("arb_done_at_ack", done, 1);
      n = 0;
      while (busy !== 1'b0 && n < 500) begin tick(); n++; end
      check("arb_host_len", n, FRAME);
      check("arb_frames", cap_q.size() - base, 17);
      check("arb_host_word", cap_q[base+16], 20'h3C0F1);

      // start pending during a host frame
      base = cap_q.size();
      wr_data = 20'h0F0F0; wr_req = 1'b1;
      tick();
      check("pend_ack", wr_ack, 1);
      repeat (99) tick();
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (busy !== 1'b0 && n < 500) begin tick(); n++; end
      check("pend_done_cleared", done, 0);
      check("pend_host_word", cap_q[base], 20'h0F0F0);
      tick();
      check("pend_busy_next", busy, 1);
      check("pend_addr", rom_addr, 0);
      check("pend_no_ack", wr_ack, 0);
      n = 0;
      while (done !== 1'b1 && n < 7000) begin tick(); n++; end
      check("pend_init_len", n, 5648);

      // restart during word 7
      base = cap_q.size();
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (rom_addr !== 4'd7 && n < 4000) begin tick(); n++; end
      check("rs_word7_cycle", n, 2471);
      repeat (100) tick();
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (busy !== 1'b0 && n < 7000) begin tick(); n++; end
      check("rs_done_between", done, 0);
      check("rs_first_frames", cap_q.size() - base, 16);
      n = 0;
      while (done !== 1'b1 && n < 7000) begin tick(); n++; end
      check("rs_second_len", n, 5649);
      check("rs_total_frames", cap_q.size() - base, 32);
      check("rs_last_word", cap_q[base+31], 20'h8000F);

      // reset in the middle of SHIFT
      wr_data = 20'h12345; wr_req = 1'b1;
      repeat (50) tick();
      check("mid_select_low", select, 0);
      r0 = sclk_rises;
      rst_n = 1'b0;
      tick();
      check("mrst_select", select, 1);
      check("mrst_sclk", sclk, 0);
      check("mrst_sdata", sdata, 0);
      check("mrst_busy", busy, 0);
      check("mrst_done", done, 0);
      repeat (4) tick();
      check("mrst_no_sclk", sclk_rises - r0, 0);
      rst_n = 1'b1;
      repeat (20) tick();
      check("mrst_not_resumed", busy, 0);
      check("mrst_select_idle", select, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
